uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte-stream requesters. It sits between the requesters and the transmitter core. A requester owns the transmitter for a whole burst, ended by a byte flagged `req_last`. The block sequences one byte at a time through the transmitter's start/busy/done handshake and releases a stalled owner after a timeout.

---
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters.
// An owner keeps the transmitter for a whole burst; a stalled owner is released after TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       locked,
  output logic                       timeout_err
);

  localparam int              OW         = $clog2(NUM_REQ);
  localparam logic [15:0]     IDLE_LIMIT = 16'(TIMEOUT - 1);
  localparam logic [OW-1:0]   PTR_RESET  = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [OW-1:0]  owner_r, owner_nxt_s;
  logic [OW-1:0]  last_gnt_r, last_gnt_nxt_s;
  logic           locked_r, locked_nxt_s;
  logic [15:0]    idle_cnt_r, idle_cnt_nxt_s;
  logic           last_q_r, last_q_nxt_s;
  logic [7:0]     tx_byte_r, tx_byte_nxt_s;
  logic           tx_start_r, tx_start_nxt_s;
  logic [NUM_REQ-1:0] ack_r, ack_nxt_s;
  logic           timeout_err_r, timeout_nxt_s;

  logic           grant_found_s;
  logic [OW-1:0]  grant_idx_s;
  logic [OW-1:0]  cand_s;
  logic           owner_req_s;
  logic           owner_last_s;
  logic [7:0]     owner_byte_s;
  logic           send_fire_s;
  logic           idle_expired_s;

  assign owner_req_s    = req[owner_r];
  assign owner_last_s   = req_last[owner_r];
  assign owner_byte_s   = req_data[{owner_r, 3'b000} +: 8];
  assign send_fire_s    = (state_r == ST_SEND) && owner_req_s && !tx_busy;
  assign idle_expired_s = (state_r == ST_SEND) && !owner_req_s && (idle_cnt_r == IDLE_LIMIT);

  // Round-robin search starting one past the last granted index
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {OW{1'b0}};
    cand_s        = {OW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s        = OW'((int'(last_gnt_r) + i) % NUM_REQ);
      grant_idx_s   = (req[cand_s] && !grant_found_s) ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | req[cand_s];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      owner_r       <= {OW{1'b0}};
      last_gnt_r    <= PTR_RESET;
      locked_r      <= 1'b0;
      idle_cnt_r    <= 16'd0;
      last_q_r      <= 1'b0;
      tx_byte_r     <= 8'd0;
      tx_start_r    <= 1'b0;
      ack_r         <= {NUM_REQ{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      owner_r       <= owner_nxt_s;
      last_gnt_r    <= last_gnt_nxt_s;
      locked_r      <= locked_nxt_s;
      idle_cnt_r    <= idle_cnt_nxt_s;
      last_q_r      <= last_q_nxt_s;
      tx_byte_r     <= tx_byte_nxt_s;
      tx_start_r    <= tx_start_nxt_s;
      ack_r         <= ack_nxt_s;
      timeout_err_r <= timeout_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (send_fire_s) begin
          state_nxt_s = ST_WAIT;
        end else if (idle_expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_nxt_s = last_q_r ? ST_IDLE : ST_SEND;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and burst bookkeeping
  always_comb begin
    owner_nxt_s    = owner_r;
    last_gnt_nxt_s = last_gnt_r;
    locked_nxt_s   = locked_r;
    idle_cnt_nxt_s = idle_cnt_r;
    last_q_nxt_s   = last_q_r;
    tx_byte_nxt_s  = tx_byte_r;
    tx_start_nxt_s = 1'b0;
    ack_nxt_s      = {NUM_REQ{1'b0}};
    timeout_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          owner_nxt_s    = grant_idx_s;
          locked_nxt_s   = 1'b1;
          idle_cnt_nxt_s = 16'd0;
        end else begin
          locked_nxt_s   = 1'b0;
        end
      end
      ST_SEND: begin
        if (send_fire_s) begin
          tx_byte_nxt_s      = owner_byte_s;
          last_q_nxt_s       = owner_last_s;
          tx_start_nxt_s     = 1'b1;
          ack_nxt_s[owner_r] = 1'b1;
        end else if (idle_expired_s) begin
          timeout_nxt_s  = 1'b1;
          locked_nxt_s   = 1'b0;
          last_gnt_nxt_s = owner_r;
        end else if (!owner_req_s) begin
          // Saturate rather than wrap so a huge TIMEOUT can never be skipped
          idle_cnt_nxt_s = (idle_cnt_r == 16'hFFFF) ? idle_cnt_r : idle_cnt_r + 16'd1;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (last_q_r) begin
            locked_nxt_s   = 1'b0;
            last_gnt_nxt_s = owner_r;
          end else begin
            idle_cnt_nxt_s = 16'd0;
          end
        end else begin
          idle_cnt_nxt_s = idle_cnt_r;
        end
      end
      default: begin
        locked_nxt_s = 1'b0;
      end
    endcase
  end

  assign ack         = ack_r;
  assign tx_start    = tx_start_r;
  assign tx_byte     = tx_byte_r;
  assign owner       = owner_r;
  assign locked      = locked_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester/transmitter models, expected-byte scoreboard,
// a table of burst scenarios and hand-written latency, stall, timeout and reset sequences.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int TMO   = 8;
  localparam int FRAME = 6;
  localparam int NVEC  = 9;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] ack;
  logic            tx_start;
  logic [7:0]      tx_byte;
  logic            tx_busy;
  logic            tx_done;
  logic [1:0]      owner;
  logic            locked;
  logic            timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy),
    .tx_done(tx_done), .owner(owner), .locked(locked), .timeout_err(timeout_err)
  );

  typedef struct {
    int         grp;
    int         id;
    logic [7:0] data;
    logic       last;
    int         gap;
    int         exp_id;
    logic [7:0] exp_byte;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  vec_t       vecs [NVEC];
  exp_t       sb [$];
  exp_t       mon_e;
  exp_t       push_e;
  logic [8:0] rq [NREQ][$];

  logic [NREQ-1:0]   d_req;
  logic [8*NREQ-1:0] d_data;
  logic [NREQ-1:0]   d_last;
  bit model_on;
  bit busy_force;
  int tx_cnt;
  int checks;
  int errors;
  int cyc;
  int bad;
  int seen_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic expect_byte(input int id, input logic [7:0] b);
    push_e.id = id;
    push_e.b  = b;
    sb.push_back(push_e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_on = 1'b0;
    busy_force = 1'b0;
    d_req = 4'b0000;
    d_data = 32'h0;
    d_last = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (c < 3000 && !(sb.size() == 0 && !locked && rq_empty())) begin
      @(negedge clk);
      c++;
    end
    chk(name, (c < 3000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: busy for FRAME cycles after tx_start, then a one-cycle tx_done
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    tx_cnt  = 0;
    forever begin
      @(posedge clk);
      #2;
      tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (tx_start) tx_cnt = FRAME;
      tx_busy = (tx_cnt > 0) || busy_force;
    end
  end

  // Requester driver: queue-based model when enabled, otherwise direct values from the test
  initial begin
    req = 4'b0000;
    req_data = 32'h0;
    req_last = 4'b0000;
    forever begin
      @(posedge clk);
      #2;
      if (model_on) begin
        for (int i = 0; i < NREQ; i++) begin
          if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
          req[i] = (rq[i].size() > 0);
          if (rq[i].size() > 0) begin
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
          end
        end
      end else begin
        req      = d_req;
        req_data = d_data;
        req_last = d_last;
      end
    end
  end

  // Scoreboard monitor: every tx_start consumes one expected {owner, byte}
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: tx_byte=%0h owner=%0d with nothing expected", tx_byte, owner);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_byte", {24'h0, tx_byte}, {24'h0, mon_e.b});
          chk("sb_ack", {28'h0, ack}, 32'd1 << mon_e.id);
          chk("sb_owner", {30'h0, owner}, mon_e.id);
        end
      end else if (ack != 4'b0000) begin
        chk("ack_without_start", {28'h0, ack}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    d_req = 4'b0000;
    d_data = 32'h0;
    d_last = 4'b0000;
    model_on = 1'b0;
    busy_force = 1'b0;

    // {grp, id, data, last, gap | expected owner, expected byte}
    vecs[0] = '{0, 0, 8'h10, 1'b1, 0, 0, 8'h10};
    vecs[1] = '{0, 1, 8'h11, 1'b1, 0, 1, 8'h11};
    vecs[2] = '{0, 2, 8'h12, 1'b1, 0, 2, 8'h12};
    vecs[3] = '{0, 3, 8'h13, 1'b1, 0, 3, 8'h13};
    vecs[4] = '{0, 0, 8'h10, 1'b1, 0, 0, 8'h10};
    vecs[5] = '{1, 1, 8'h01, 1'b0, 0, 1, 8'h01};
    vecs[6] = '{1, 1, 8'h02, 1'b0, 0, 1, 8'h02};
    vecs[7] = '{1, 1, 8'h03, 1'b1, 3, 1, 8'h03};
    vecs[8] = '{1, 0, 8'h55, 1'b1, 0, 0, 8'h55};

    do_reset();
    chk("rst_ack", {28'h0, ack}, 32'd0);
    chk("rst_tx_start", {31'h0, tx_start}, 32'd0);
    chk("rst_tx_byte", {24'h0, tx_byte}, 32'd0);
    chk("rst_owner", {30'h0, owner}, 32'd0);
    chk("rst_locked", {31'h0, locked}, 32'd0);
    chk("rst_timeout_err", {31'h0, timeout_err}, 32'd0);

    // Single-byte burst from requester 2: grant latency and release
    d_req = 4'b0100; d_data = 32'h00A5_0000; d_last = 4'b0100;
    expect_byte(2, 8'hA5);
    @(negedge clk);
    chk("a_not_yet_locked", {31'h0, locked}, 32'd0);
    @(negedge clk);
    chk("a_locked", {31'h0, locked}, 32'd1);
    chk("a_owner", {30'h0, owner}, 32'd2);
    chk("a_no_start_yet", {31'h0, tx_start}, 32'd0);
    @(negedge clk);
    chk("a_start", {31'h0, tx_start}, 32'd1);
    chk("a_ack", {28'h0, ack}, 32'h4);
    chk("a_byte", {24'h0, tx_byte}, 32'hA5);
    d_req = 4'b0000;
    cyc = 0;
    while (!tx_done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("a_done_seen", {31'h0, tx_done}, 32'd1);
    chk("a_locked_at_done", {31'h0, locked}, 32'd1);
    @(negedge clk);
    chk("a_released", {31'h0, locked}, 32'd0);

    // Transmitter busy for 50 cycles while the owner waits in SEND
    do_reset();
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    d_req = 4'b0010; d_data = 32'h0000_3C00; d_last = 4'b0010;
    expect_byte(1, 8'h3C);
    repeat (2) @(negedge clk);
    chk("b_locked", {31'h0, locked}, 32'd1);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_start || timeout_err || !locked) bad++;
    end
    chk("b_stall_clean", bad, 32'd0);
    busy_force = 1'b0;
    cyc = 0;
    while (tx_busy && cyc < 10) begin @(negedge clk); cyc++; end
    chk("b_busy_low", {31'h0, tx_busy}, 32'd0);
    chk("b_no_start_same_cycle", {31'h0, tx_start}, 32'd0);
    @(negedge clk);
    chk("b_start_after_busy", {31'h0, tx_start}, 32'd1);
    d_req = 4'b0000;
    wait_drain("b_drain");

    // Owner 3 stalls mid-burst; forced release then requester 0 is served
    do_reset();
    d_req = 4'b1000; d_data = 32'h7700_0000; d_last = 4'b0000;
    expect_byte(3, 8'h77);
    cyc = 0;
    while (!ack[3] && cyc < 20) begin @(negedge clk); cyc++; end
    chk("c_ack3", {31'h0, ack[3]}, 32'd1);
    d_req = 4'b0001; d_data = 32'h0000_0099; d_last = 4'b0001;
    expect_byte(0, 8'h99);
    cyc = 0;
    while (!tx_done && cyc < 100) begin @(negedge clk); cyc++; end
    chk("c_done_seen", {31'h0, tx_done}, 32'd1);
    bad = 0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (timeout_err || !locked) bad++;
    end
    chk("c_no_early_timeout", bad, 32'd0);
    @(negedge clk);
    chk("c_timeout_pulse", {31'h0, timeout_err}, 32'd1);
    chk("c_released", {31'h0, locked}, 32'd0);
    @(negedge clk);
    chk("c_pulse_one_cycle", {31'h0, timeout_err}, 32'd0);
    chk("c_regrant_locked", {31'h0, locked}, 32'd1);
    chk("c_regrant_owner", {30'h0, owner}, 32'd0);
    @(negedge clk);
    chk("c_start_req0", {31'h0, tx_start}, 32'd1);
    d_req = 4'b0000;
    wait_drain("c_drain");

    // Reset one cycle after tx_start; the late tx_done must be ignored
    do_reset();
    d_req = 4'b0100; d_data = 32'h005A_0000; d_last = 4'b0100;
    expect_byte(2, 8'h5A);
    cyc = 0;
    while (!tx_start && cyc < 20) begin @(negedge clk); cyc++; end
    chk("d_start_seen", {31'h0, tx_start}, 32'd1);
    d_req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("d_rst_ack", {28'h0, ack}, 32'd0);
    chk("d_rst_tx_start", {31'h0, tx_start}, 32'd0);
    chk("d_rst_tx_byte", {24'h0, tx_byte}, 32'd0);
    chk("d_rst_owner", {30'h0, owner}, 32'd0);
    chk("d_rst_locked", {31'h0, locked}, 32'd0);
    chk("d_rst_timeout_err", {31'h0, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (tx_done) seen_done = 1;
      if (ack != 4'b0000 || tx_start || tx_byte != 8'h00 || owner != 2'd0 || locked || timeout_err) bad++;
    end
    chk("d_done_arrived", seen_done, 32'd1);
    chk("d_quiet_after_reset", bad, 32'd0);
    d_req = 4'b1111; d_data = 32'h4433_2211; d_last = 4'b1111;
    expect_byte(0, 8'h11);
    repeat (2) @(negedge clk);
    chk("d_ptr_reset_owner", {30'h0, owner}, 32'd0);
    chk("d_ptr_locked", {31'h0, locked}, 32'd1);
    @(negedge clk);
    chk("d_start", {31'h0, tx_start}, 32'd1);
    d_req = 4'b0000;
    wait_drain("d_drain");

    // Table-driven burst scenarios, each from a fresh reset
    for (int g = 0; g < 2; g++) begin
      do_reset();
      model_on = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
        if (vecs[i].grp == g) begin
          rq[vecs[i].id].push_back({vecs[i].last, vecs[i].data});
          expect_byte(vecs[i].exp_id, vecs[i].exp_byte);
          repeat (vecs[i].gap) @(negedge clk);
        end
      end
      wait_drain($sformatf("group%0d_drain", g));
      model_on = 1'b0;
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
